// File: rtl/fx_match_share_ctrl.sv
// Round-robin front end that time-shares one fixed-latency format-match unit among N_REQ
// channels, tags each issue with its channel id and returns results in issue order.
module fx_match_share_ctrl #(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned IW         = 12,
  parameter int unsigned OW         = 14,
  parameter int unsigned CV_LAT     = 1,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned IDW        = $clog2(N_REQ),
  parameter int unsigned OCW        = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ*IW-1:0] req_data,
  output logic [N_REQ-1:0]    req_ready,
  output logic [IW-1:0]       cv_i_data,
  input  logic [OW-1:0]       cv_o_data,
  output logic                out_valid,
  output logic [OW-1:0]       out_data,
  output logic [IDW-1:0]      out_id,
  input  logic                out_ready,
  output logic [OCW-1:0]      occ
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [IDW-1:0]    ptr_q, ptr_d, gnt;
  logic              gnt_found, issue, push, pop;
  logic [CV_LAT-1:0] tag_vld_q, tag_vld_d;
  logic [IDW-1:0]    tag_id_q [CV_LAT];
  logic [IDW-1:0]    tag_id_d [CV_LAT];
  logic [OW-1:0]     mem_q    [FIFO_DEPTH];
  logic [IDW-1:0]    mem_id_q [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OCW-1:0]    cnt_q, cnt_d, occ_q, occ_d;

  // First requester at or after ptr, wrapping around.
  always_comb begin
    gnt       = ptr_q;
    gnt_found = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!gnt_found && req_valid[IDW'((32'(ptr_q) + i) % N_REQ)]) begin
        gnt_found = 1'b1;
        gnt       = IDW'((32'(ptr_q) + i) % N_REQ);
      end
    end
  end

  // occ counts in-flight plus stored results, so it is the credit check for the FIFO.
  assign issue     = (|req_valid) && (occ_q < OCW'(FIFO_DEPTH)) && !rst;
  assign req_ready = issue ? (N_REQ'(1) << gnt) : '0;
  assign cv_i_data = issue ? req_data[gnt*IW +: IW] : '0;

  assign push      = tag_vld_q[CV_LAT-1];
  assign out_valid = (cnt_q != '0);
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign out_id    = out_valid ? mem_id_q[rd_ptr_q] : '0;
  assign occ       = occ_q;

  always_comb begin
    ptr_d = ptr_q;
    if (issue) ptr_d = (gnt == IDW'(N_REQ - 1)) ? '0 : gnt + IDW'(1);

    tag_vld_d    = '0;
    tag_vld_d[0] = issue;
    tag_id_d[0]  = gnt;
    for (int unsigned i = 1; i < CV_LAT; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_id_d[i]  = tag_id_q[i-1];
    end

    wr_ptr_d = wr_ptr_q;
    if (push) wr_ptr_d = (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    rd_ptr_d = rd_ptr_q;
    if (pop) rd_ptr_d = (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);

    cnt_d = cnt_q;
    if (push && !pop) cnt_d = cnt_q + OCW'(1);
    if (!push && pop) cnt_d = cnt_q - OCW'(1);

    occ_d = occ_q;
    if (issue && !pop) occ_d = occ_q + OCW'(1);
    if (!issue && pop) occ_d = occ_q - OCW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q     <= '0;
      tag_vld_q <= '0;
      for (int unsigned i = 0; i < CV_LAT; i++) tag_id_q[i] <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      occ_q     <= '0;
    end else begin
      ptr_q     <= ptr_d;
      tag_vld_q <= tag_vld_d;
      for (int unsigned i = 0; i < CV_LAT; i++) tag_id_q[i] <= tag_id_d[i];
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      occ_q     <= occ_d;
    end
  end

  // Storage needs no reset: out_data/out_id are gated by out_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q]    <= cv_o_data;
      mem_id_q[wr_ptr_q] <= tag_id_q[CV_LAT-1];
    end
  end

endmodule

// File: tb/tb_fx_match_share_ctrl.sv
// Random and directed bench for fx_match_share_ctrl against a queue-based reference model;
// the format-match unit is emulated as sign extension plus a CV_LAT-cycle delay.
module tb_fx_match_share_ctrl;

  localparam int unsigned N     = 4;
  localparam int unsigned IW    = 12;
  localparam int unsigned OW    = 14;
  localparam int unsigned LAT   = 1;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned IDW   = $clog2(N);
  localparam int unsigned OCW   = $clog2(DEPTH + 1);

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [N-1:0]        req_valid = '0;
  logic [N*IW-1:0]     req_data = '0;
  logic [N-1:0]        req_ready;
  logic [IW-1:0]       cv_i_data;
  logic [OW-1:0]       cv_o_data;
  logic                out_valid;
  logic [OW-1:0]       out_data;
  logic [IDW-1:0]      out_id;
  logic                out_ready = 1'b0;
  logic [OCW-1:0]      occ;

  fx_match_share_ctrl #(
    .N_REQ(N), .IW(IW), .OW(OW), .CV_LAT(LAT), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .cv_i_data(cv_i_data), .cv_o_data(cv_o_data),
    .out_valid(out_valid), .out_data(out_data), .out_id(out_id),
    .out_ready(out_ready), .occ(occ)
  );

  always #5 clk = ~clk;

  function automatic logic [OW-1:0] sext(input logic [IW-1:0] s);
    return {{(OW-IW){s[IW-1]}}, s};
  endfunction

  logic [OW-1:0] unit_q [LAT];
  always @(posedge clk) begin
    unit_q[0] <= sext(cv_i_data);
    for (int i = 1; i < LAT; i++) unit_q[i] <= unit_q[i-1];
  end
  assign cv_o_data = unit_q[LAT-1];

  typedef struct {
    logic [OW-1:0]  d;
    logic [IDW-1:0] id;
    int             rem;
  } item_t;

  item_t inflight[$];
  item_t fifo[$];
  int    m_ptr, m_occ;
  int    n_checks = 0;
  int    n_fail = 0;

  logic [N-1:0]   obs_ready;
  logic           obs_valid;
  logic [OW-1:0]  obs_data;
  logic [IDW-1:0] obs_id;
  logic [OCW-1:0] obs_occ;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive, compare against the model, then advance the model across the edge.
  task automatic run_cycle(input logic [N-1:0] rv, input logic [N*IW-1:0] rd,
                           input logic ordy, input logic r);
    int     eg;
    logic   eissue, epop;
    item_t  it;
    @(negedge clk);
    req_valid = rv; req_data = rd; out_ready = ordy; rst = r;
    #1;
    eg = 0;
    for (int i = N - 1; i >= 0; i--) if (rv[(m_ptr + i) % N]) eg = (m_ptr + i) % N;
    eissue = (rv != '0) && (m_occ < DEPTH) && !r;
    check_eq("req_ready", 32'(req_ready), eissue ? (32'd1 << eg) : 32'd0);
    check_eq("cv_i_data", 32'(cv_i_data), eissue ? 32'(rd[eg*IW +: IW]) : 32'd0);
    check_eq("out_valid", 32'(out_valid), 32'(fifo.size() > 0));
    check_eq("out_data", 32'(out_data), (fifo.size() > 0) ? 32'(fifo[0].d) : 32'd0);
    check_eq("out_id", 32'(out_id), (fifo.size() > 0) ? 32'(fifo[0].id) : 32'd0);
    check_eq("occ", 32'(occ), 32'(m_occ));
    obs_ready = req_ready; obs_valid = out_valid; obs_data = out_data;
    obs_id = out_id; obs_occ = occ;
    epop = (fifo.size() > 0) && ordy;
    @(posedge clk);
    if (r) begin
      inflight.delete(); fifo.delete(); m_ptr = 0; m_occ = 0;
    end else begin
      if (epop) void'(fifo.pop_front());
      foreach (inflight[i]) inflight[i].rem--;
      while (inflight.size() > 0 && inflight[0].rem == 0) fifo.push_back(inflight.pop_front());
      if (eissue) begin
        it.d = sext(rd[eg*IW +: IW]); it.id = IDW'(eg); it.rem = LAT;
        inflight.push_back(it);
        m_ptr = (eg + 1) % N;
      end
      m_occ = m_occ + int'(eissue) - int'(epop);
    end
  endtask

  function automatic logic [N*IW-1:0] rand_data();
    logic [N*IW-1:0] v;
    for (int i = 0; i < N; i++) v[i*IW +: IW] = IW'($urandom);
    return v;
  endfunction

  logic [N*IW-1:0] d;
  int              cnt, k;
  int              ids[$];

  initial begin
    m_ptr = 0; m_occ = 0;
    repeat (2) @(posedge clk);

    // Reset with every channel requesting.
    run_cycle('1, rand_data(), 1'b1, 1'b1);
    check_eq("rst_ready", 32'(obs_ready), 32'd0);
    check_eq("rst_occ", 32'(obs_occ), 32'd0);

    // Single sample on channel 2.
    d = rand_data(); d[2*IW +: IW] = 12'h800;
    run_cycle(4'b0100, d, 1'b0, 1'b0);
    check_eq("single_ready", 32'(obs_ready), 32'h4);
    run_cycle('0, '0, 1'b0, 1'b0);
    check_eq("single_t1", 32'(obs_valid), 32'd0);
    run_cycle('0, '0, 1'b1, 1'b0);
    check_eq("single_valid", 32'(obs_valid), 32'd1);
    check_eq("single_data", 32'(obs_data), 32'h3800);
    check_eq("single_id", 32'(obs_id), 32'd2);

    // Full rate, all channels: one grant per cycle, rotating from ptr=3.
    for (int c = 0; c < 10; c++) begin
      run_cycle('1, rand_data(), 1'b1, 1'b0);
      check_eq("rr_grant", 32'(obs_ready), 32'd1 << ((3 + c) % N));
      if (c >= 2) check_eq("rr_occ", 32'(obs_occ), 32'd2);
    end

    // Back-pressure from a fresh reset: exactly DEPTH accepts, then drain in order.
    run_cycle('0, '0, 1'b0, 1'b1);
    cnt = 0;
    for (int c = 0; c < 7; c++) begin
      run_cycle('1, rand_data(), 1'b0, 1'b0);
      if (obs_ready != '0) cnt++;
    end
    check_eq("bp_accepts", 32'(cnt), 32'd4);
    check_eq("bp_ready", 32'(obs_ready), 32'd0);
    check_eq("bp_occ", 32'(obs_occ), 32'd4);
    ids.delete();
    for (int c = 0; c < 6; c++) begin
      run_cycle('0, '0, 1'b1, 1'b0);
      if (obs_valid) ids.push_back(int'(obs_id));
    end
    check_eq("bp_drained", 32'(ids.size()), 32'd4);
    foreach (ids[i]) check_eq("bp_order", 32'(ids[i]), 32'(i));
    run_cycle('1, rand_data(), 1'b1, 1'b0);
    check_eq("bp_resume", 32'(obs_ready != '0), 32'd1);

    // Alternation between channels 0 and 3 with ptr parked at 3.
    run_cycle('0, '0, 1'b1, 1'b1);
    run_cycle(4'b0100, rand_data(), 1'b1, 1'b0);
    for (int c = 0; c < 4; c++) begin
      run_cycle(4'b1001, rand_data(), 1'b1, 1'b0);
      check_eq("alt_grant", 32'(obs_ready), (c % 2 == 0) ? 32'h8 : 32'h1);
    end

    // Reset with results in flight and stored: nothing stale may emerge.
    for (int c = 0; c < 6; c++) run_cycle('1, rand_data(), 1'b0, 1'b0);
    run_cycle('0, '0, 1'b0, 1'b1);
    run_cycle('0, '0, 1'b1, 1'b0);
    check_eq("mrst_valid", 32'(obs_valid), 32'd0);
    check_eq("mrst_occ", 32'(obs_occ), 32'd0);
    cnt = 0;
    for (int c = 0; c < 4; c++) begin
      run_cycle('0, '0, 1'b1, 1'b0);
      if (obs_valid) cnt++;
    end
    check_eq("mrst_stale", 32'(cnt), 32'd0);

    // Random traffic, back-pressure and occasional reset.
    for (int c = 0; c < 600; c++) begin
      k = $urandom_range(0, 63);
      run_cycle(N'($urandom), rand_data(), ($urandom_range(0, 9) < 7), (k == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
